branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised branch unit for the RISC-V core: resolves conditional branches for any XLEN, keeps a direct-mapped table of 2-bit saturating direction predictors, and counts branches and mispredictions. Fetch reads a prediction combinationally. Execute presents resolved operands. One cycle later the unit reports the actual outcome and whether the prediction was wrong, and updates the predictor table.

## Interface
Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 16, number of predictor entries; must be a power of two, ≥2.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pred_pc_i  in  XLEN  fetch PC to predict.
- pred_taken_o  out  1  predicted direction for pred_pc_i (combinational).
- res_valid_i  in  1  a branch is presented for resolution this cycle.
- res_pc_i  in  XLEN  PC of the resolving branch.
- res_funct3_i  in  3  branch funct3.
- res_a_i, res_b_i  in  XLEN  rs1/rs2 values.
- res_pred_i  in  1  direction that was predicted for this branch at fetch.
- res_done_o  out  1  registered pulse; outcome outputs are valid this cycle.
- res_taken_o  out  1  registered actual outcome.
- res_mispredict_o  out  1  registered; res_taken_o != captured res_pred_i.
- res_illegal_o  out  1  registered; funct3 was 010 or 011.
- stat_clr_i  in  1  synchronous clear of both statistic counters.
- stat_branches_o  out  STAT_W  legal branches resolved.
- stat_mispred_o  out  STAT_W  mispredictions.

## Operation
- Index: IDX = log2(BHT_DEPTH). Entry index = pc[IDX+1:2].
- Compare, signed or unsigned as funct3 requires:
  - 000 beq: a==b.
  - 001 bne: a!=b.
  - 100 blt: signed a<b.
  - 101 bge: signed a≥b.
  - 110 bltu: unsigned a<b.
  - 111 bgeu: unsigned a≥b.
- Equality is a full-width reduction producing a single bit.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
  - Prediction is the counter MSB.
  - Taken increments and saturates at ST. Not-taken decrements and saturates at SNT.
- Resolve cycle, when res_valid_i=1 and funct3 is legal:
  - Compute the outcome.
  - Register res_done_o=1, res_taken_o and res_mispredict_o.
  - Write the updated counter at the res_pc_i index on the same edge.
  - Increment stat_branches_o, and stat_mispred_o if mispredicted.
- Illegal funct3 (010, 011):
  - res_done_o=1, res_illegal_o=1, res_taken_o=0, res_mispredict_o=0.
  - No table update, no statistic increment.
- res_valid_i=0: next cycle res_done_o, res_taken_o, res_mispredict_o and res_illegal_o are all 0.
- Statistic counters saturate at all-ones and do not wrap.
- stat_clr_i has priority over an increment in the same cycle; the counter goes to 0.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - Every table entry becomes WNT.
  - res_done_o, res_taken_o, res_mispredict_o, res_illegal_o and both stat counters become 0.
  - pred_taken_o therefore reads 0 after reset.
- Reset asserted with res_valid_i=1: reset wins. No update, no stat increment.
- pred_taken_o: zero-latency combinational read of the current table.
- Resolve latency is 1 cycle: res_valid_i at edge N gives outputs during cycle N+1.
- Back-to-back resolves are accepted every cycle. There is no stall or backpressure.
- Same index read and written in the same cycle: pred_taken_o returns the pre-update value, with no bypass. The new value is visible from the next cycle.
- Two consecutive resolves to the same index: the second uses the counter already written by the first.

## Structure
- Shared package branch_pkg:
  - funct3 constants (F3_BEQ … F3_BGEU).
  - Counter state enum bht_state_t (SNT/WNT/WT/ST).
  - Reset value BHT_RESET = WNT.
- Sub-module branch_cmp_core: combinational, parametrised by XLEN.
  - Inputs: a, b, funct3.
  - Outputs: taken, illegal.
- The top level holds the counter array, the output registers and the stat counters.

## Test plan
- Reset, then pred_pc_i=0x40 → pred_taken_o=0. Stats read 0.
- beq a=b=0xDEADBEEF, res_pred_i=0, pc=0x40 → next cycle res_taken_o=1, res_mispredict_o=1. Entry 0 becomes WT; pred_taken_o for 0x40 reads 1; stat_branches_o=1, stat_mispred_o=1.
- Signed versus unsigned, a=0xFFFFFFFF, b=1:
  - blt → taken=1.
  - bltu → taken=0.
  - bge → 0.
  - bgeu → 1.
- Saturation: four taken resolves at pc=0x44 → counter ST. One not-taken → WT, prediction still 1. Counter never exceeds ST.
- funct3=010 with res_valid_i=1 → res_illegal_o=1, res_done_o=1, res_taken_o=0. Table and stats unchanged.
- Simultaneous update and read of pc=0x48 from WNT with a taken resolve → pred_taken_o=0 in that cycle, 1 in the next cycle.
- Stat boundary, STAT_W=4: 16 legal resolves → stat_branches_o stays at 15. stat_clr_i asserted with res_valid_i=1 → 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: funct3 encodings, the 2-bit
// direction counter type and its saturating update rule.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Strongly/weakly not-taken, weakly/strongly taken; MSB is the prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET = WNT;

  // Move one step toward the resolved direction, saturating at both ends.
  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    bht_state_t n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = BHT_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational RISC-V branch condition evaluator for any operand width.
module branch_cmp_core
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign a_s  = $signed(a);
  assign b_s  = $signed(b);
  // Equality collapses the full operand width into one bit.
  assign eq   = ~|(a ^ b);
  assign lt_s = a_s < b_s;
  assign lt_u = a < b;

  // Select the comparison that funct3 names; 010/011 are not branches.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a direct-mapped table of 2-bit direction counters
// and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  input  logic              res_valid_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic [2:0]        res_funct3_i,
  input  logic [XLEN-1:0]   res_a_i,
  input  logic [XLEN-1:0]   res_b_i,
  input  logic              res_pred_i,
  output logic              res_done_o,
  output logic              res_taken_o,
  output logic              res_mispredict_o,
  output logic              res_illegal_o,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IDX = $clog2(BHT_DEPTH);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [IDX-1:0] pred_idx;
  logic [IDX-1:0] res_idx;
  logic [1:0]     pred_state;
  logic           cmp_taken;
  logic           cmp_illegal;
  logic           legal_vld;
  logic           mispredict;
  logic           unused_pc_bits;

  bht_state_t bht_q [BHT_DEPTH];
  bht_state_t bht_d [BHT_DEPTH];

  logic              done_q, done_d;
  logic              taken_q, taken_d;
  logic              mispredict_q, mispredict_d;
  logic              illegal_q, illegal_d;
  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;

  // Word-aligned PCs: the two LSBs and the bits above the index are ignored.
  assign pred_idx       = pred_pc_i[IDX+1:2];
  assign res_idx        = res_pc_i[IDX+1:2];
  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX+2], pred_pc_i[1:0],
                            res_pc_i[XLEN-1:IDX+2], res_pc_i[1:0]};

  // Prediction reads the registered table, so a same-cycle update is not bypassed.
  assign pred_state   = bht_q[pred_idx];
  assign pred_taken_o = pred_state[1];

  branch_cmp_core #(
    .XLEN(XLEN)
  ) u_cmp (
    .a       (res_a_i),
    .b       (res_b_i),
    .funct3  (res_funct3_i),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign legal_vld  = res_valid_i & ~cmp_illegal;
  assign mispredict = legal_vld & (cmp_taken != res_pred_i);

  // Next state of the predictor table: only a legal resolve touches its entry.
  always_comb begin
    bht_d = bht_q;
    if (legal_vld) begin
      bht_d[res_idx] = bht_next(bht_q[res_idx], cmp_taken);
    end
  end

  // Next state of the outcome registers and statistics; clear beats increment.
  always_comb begin
    done_d       = res_valid_i;
    taken_d      = legal_vld & cmp_taken;
    mispredict_d = mispredict;
    illegal_d    = res_valid_i & cmp_illegal;
    branches_d   = branches_q;
    mispred_d    = mispred_q;
    if (stat_clr_i) begin
      branches_d = '0;
      mispred_d  = '0;
    end else begin
      if (legal_vld) begin
        branches_d = sat_inc(branches_q);
      end
      if (mispredict) begin
        mispred_d = sat_inc(mispred_q);
      end
    end
  end

  // Predictor table register; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

  // Outcome and statistic registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      branches_q   <= '0;
      mispred_q    <= '0;
    end else begin
      done_q       <= done_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      branches_q   <= branches_d;
      mispred_q    <= mispred_d;
    end
  end

  assign res_done_o       = done_q;
  assign res_taken_o      = taken_q;
  assign res_mispredict_o = mispredict_q;
  assign res_illegal_o    = illegal_q;
  assign stat_branches_o  = branches_q;
  assign stat_mispred_o   = mispred_q;

endmodule
